// File: rtl/bound_flasher_ctrl.sv
// bound_flasher_ctrl
//   Sequencer in front of the 16-LED bound flasher. It takes a raw push-button,
//   synchronises and debounces it, and turns the rising edge of the debounced
//   level into a launch. It then holds flick high until the flasher leaves
//   INIT, forwards the user's button level while the sweep runs (so the
//   mid-sweep kick-back still works), and waits for the flasher to return to
//   all-off after BLINK. Runs may be auto-repeated. The flasher only advances
//   on cycles where step_en is high; step_en comes from a programmable
//   divider that runs only while a launch is in progress.
//
//   Optional build macro: FLASHER_WDOG_EN
//     defined   : a stall watchdog aborts LAUNCH/RUN after 64 consecutive
//                 steps with leds_in unchanged (err pulse, back to IDLE).
//     undefined : no watchdog logic, err tied low.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active-low
//   btn_raw    in   raw flick push-button (asynchronous)
//   cfg_div    in   step period minus 1, in clk cycles (latched at launch)
//   cfg_runs   in   runs per launch, 0 treated as 1 (latched at launch)
//   leds_in    in   flasher LED vector fed back
//   step_en    out  one-cycle clock-enable pulse to the flasher
//   flick_out  out  flick level to the flasher
//   busy       out  high whenever the FSM is not in IDLE
//   done       out  one-cycle pulse after the final requested run
//   err        out  one-cycle pulse on watchdog abort
//   runs_done  out  runs completed since the last launch
//
// State    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a debounced button press
// S_LAUNCH | flick held high until the flasher leaves INIT (leds != 0)
// S_RUN    | sweep in progress, flick follows the debounced button
// S_TAIL   | BLINK reached, waiting for leds to go dark to close the run

module bound_flasher_ctrl #(
  parameter int DIV_W        = 24,
  parameter int DEBOUNCE_CYC = 16,
  parameter int RUN_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [RUN_W-1:0] cfg_runs,
  input  logic [15:0]      leds_in,
  output logic             step_en,
  output logic             flick_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [RUN_W-1:0] runs_done
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_TAIL   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_sync1;
  logic             r_sync2;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_btn_db;
  logic             r_btn_db_d;
  logic             w_start;

  logic [DIV_W-1:0] r_div_q;
  logic [DIV_W-1:0] r_div_cnt;
  logic             w_step;
  logic             w_enter_launch;

  logic [RUN_W-1:0] r_runs_q;
  logic [RUN_W-1:0] r_runs_done;
  logic [RUN_W-1:0] w_runs_sat;
  logic             w_run_closed;

  logic             r_done;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_wd_trip;

  // Input conditioning: 2-FF synchroniser, then a stability counter. The
  // debounced level only flips once the synchronised value has disagreed
  // with it for DEBOUNCE_CYC consecutive cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db_cnt   <= '0;
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
    end else begin
      r_btn_db_d <= r_btn_db;
      if (r_sync2 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_cnt <= '0;
        r_btn_db <= r_sync2;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_start = r_btn_db & ~r_btn_db_d;

  // Step divider. Held at zero in IDLE and re-zeroed on every LAUNCH entry
  // so each run starts with a full step period.
  assign w_step         = (r_state != S_IDLE) && (r_div_cnt == r_div_q);
  assign w_enter_launch = (w_state_nxt == S_LAUNCH) && (r_state != S_LAUNCH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if ((r_state == S_IDLE) || w_enter_launch || w_step) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Launch configuration is captured only on IDLE -> LAUNCH, so changes to
  // cfg_div/cfg_runs mid-launch are deferred to the next press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_q  <= '0;
      r_runs_q <= '0;
    end else if ((r_state == S_IDLE) && w_start) begin
      r_div_q  <= cfg_div;
      r_runs_q <= (cfg_runs == '0) ? RUN_W'(1) : cfg_runs;
    end
  end

  assign w_runs_sat   = (r_runs_done == '1) ? r_runs_done : r_runs_done + 1'b1;
  assign w_run_closed = (r_state == S_TAIL) && (leds_in == 16'h0000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_runs_done <= '0;
    end else if ((r_state == S_IDLE) && w_start) begin
      r_runs_done <= '0;
    end else if (w_run_closed) begin
      r_runs_done <= w_runs_sat;
    end
  end

`ifdef FLASHER_WDOG_EN
  logic [5:0]  r_wd_cnt;
  logic [15:0] r_wd_prev;
  logic        r_err;
  logic        w_wd_active;

  // Stall detector: counts steps on which the flasher did not move. Any
  // state change restarts the count, so LAUNCH and RUN are judged separately.
  assign w_wd_active = (r_state == S_LAUNCH) || (r_state == S_RUN);
  assign w_wd_trip   = w_wd_active && w_step && (leds_in == r_wd_prev) &&
                       (r_wd_cnt == 6'd63);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt  <= '0;
      r_wd_prev <= '0;
    end else begin
      if (w_step) begin
        r_wd_prev <= leds_in;
      end
      if (w_state_nxt != r_state) begin
        r_wd_cnt <= '0;
      end else if (w_wd_active && w_step) begin
        if (leds_in != r_wd_prev) begin
          r_wd_cnt <= '0;
        end else if (r_wd_cnt != 6'd63) begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
    end
  end

  assign err = r_err;
`else
  assign w_wd_trip = 1'b0;
  assign err       = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and pulse decode
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (w_wd_trip) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else if (leds_in != 16'h0000) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_wd_trip) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else if (leds_in == 16'hFFFF) begin
          w_state_nxt = S_TAIL;
        end
      end
      S_TAIL: begin
        if (w_run_closed) begin
          if (w_runs_sat < r_runs_q) begin
            w_state_nxt = S_LAUNCH;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs: decoded from registered state so an async reset clears
  // them in the same cycle.
  always_comb begin
    flick_out = 1'b0;
    case (r_state)
      S_LAUNCH: flick_out = 1'b1;
      S_RUN:    flick_out = r_btn_db;
      default:  flick_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign step_en   = w_step;
  assign done      = r_done;
  assign runs_done = r_runs_done;

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
module tb_bound_flasher_ctrl;

  localparam int DIV_W = 24;
  localparam int RUN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             btn_raw = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [RUN_W-1:0] cfg_runs = '0;
  logic [15:0]      leds_in;
  logic             step_en;
  logic             flick_out;
  logic             busy;
  logic             done;
  logic             err;
  logic [RUN_W-1:0] runs_done;

  bound_flasher_ctrl #(.DIV_W(DIV_W), .DEBOUNCE_CYC(16), .RUN_W(RUN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .cfg_div   (cfg_div),
    .cfg_runs  (cfg_runs),
    .leds_in   (leds_in),
    .step_en   (step_en),
    .flick_out (flick_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .runs_done (runs_done)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Simplified bound flasher: INIT -> fill up to 16'hFFFF (BLINK) -> dark.
  // A flick seen at the 16'h003F bound kicks it back down to zero, after
  // which it climbs again. freeze pins the LEDs to exercise the stall path.
  typedef enum logic [1:0] {M_INIT, M_UP, M_KICK} m_state_t;
  m_state_t m_st;
  logic     freeze = 1'b0;
  int       kick_cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      leds_in <= 16'h0000;
      m_st    <= M_INIT;
    end else if (step_en) begin
      case (m_st)
        M_INIT: if (flick_out) begin
          leds_in <= 16'h0001;
          m_st    <= M_UP;
        end
        M_UP: begin
          if (freeze) begin
            leds_in <= leds_in;
          end else if (leds_in == 16'hFFFF) begin
            leds_in <= 16'h0000;
            m_st    <= M_INIT;
          end else if (leds_in == 16'h003F && flick_out) begin
            leds_in  <= 16'h001F;
            m_st     <= M_KICK;
            kick_cnt <= kick_cnt + 1;
          end else begin
            leds_in <= {leds_in[14:0], 1'b1};
          end
        end
        default: begin
          if (leds_in == 16'h0000) begin
            leds_in <= 16'h0001;
            m_st    <= M_UP;
          end else begin
            leds_in <= leds_in >> 1;
          end
        end
      endcase
    end
  end

  // Scoreboard: expected runs_done steps and the final count carried by done
  // are queued when a launch is driven and consumed as the DUT reports them.
  int               q_runs[$];
  int               q_final[$];
  int               busy_rise_cnt = 0;
  int               launch_cnt = 0;
  int               done_cnt = 0;
  int               err_cnt = 0;
  logic             prev_busy = 1'b0;
  logic             prev_flick = 1'b0;
  logic [RUN_W-1:0] prev_runs = '0;

  always @(negedge clk) begin
    if (busy && !prev_busy) busy_rise_cnt++;
    if (flick_out && !prev_flick) launch_cnt++;
    if (err) err_cnt++;
    if (done) begin
      done_cnt++;
      if (q_final.size() == 0) check("done_unexpected", done, 0);
      else check("done_runs_done", runs_done, q_final.pop_front());
    end
    if (runs_done != prev_runs && runs_done != '0) begin
      if (q_runs.size() == 0) check("runs_unexpected", runs_done, 0);
      else check("runs_done_step", runs_done, q_runs.pop_front());
    end
    prev_busy  = busy;
    prev_flick = flick_out;
    prev_runs  = runs_done;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(output int cyc);
    cyc = 0;
    while (!busy && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic press_and_launch(input string tag);
    int c;
    btn_raw = 1'b1;
    wait_busy(c);
    check(tag, busy, 1);
  endtask

  task automatic wait_done(input int target, input int max, input string tag);
    int c = 0;
    while (done_cnt < target && c < max) begin
      @(negedge clk);
      c++;
    end
    check(tag, done_cnt, target);
  endtask

  task automatic wait_leds(input logic [15:0] val, input int max, input string tag);
    int c = 0;
    while (leds_in !== val && c < max) begin
      @(negedge clk);
      c++;
    end
    check(tag, leds_in, val);
  endtask

  task automatic measure_period(output int per);
    int c = 0;
    while (!step_en && c < 40) begin
      @(negedge clk);
      c++;
    end
    per = 0;
    do begin
      @(negedge clk);
      per++;
    end while (!step_en && per < 40);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int per;
    int base_done;
    int base_launch;
    int base_kick;
    int base_err;

    // Reset state
    cfg_div  = 24'd3;
    cfg_runs = 4'd1;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_step_en", step_en, 0);
    check("rst_flick", flick_out, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_runs_done", runs_done, 0);
    rst = 1'b1;
    tick(3);

    // Bouncing button then a clean hold: one start, debounce latency
    base_kick = kick_cnt;
    q_runs.push_back(1);
    q_final.push_back(1);
    for (int i = 0; i < 14; i++) begin
      btn_raw = ~btn_raw;
      tick(3);
    end
    btn_raw = 1'b0;
    tick(3);
    check("bounce_no_start", busy_rise_cnt, 0);
    btn_raw = 1'b1;
    wait_busy(c);
    check("bounce_latency_19pm1", (c >= 18 && c <= 20), 1);
    check("launch_flick_high", flick_out, 1);
    btn_raw = 1'b0;
    measure_period(per);
    check("step_period_div3", per, 4);
    wait_done(1, 600, "basic_done");
    tick(5);
    check("basic_runs_done", runs_done, 1);
    check("basic_idle", busy, 0);
    check("basic_single_start", busy_rise_cnt, 1);
    check("basic_no_kick", kick_cnt, base_kick);

    // Auto-repeat x3; config changes mid-launch must be ignored
    base_done   = done_cnt;
    base_launch = launch_cnt;
    q_runs.push_back(1);
    q_runs.push_back(2);
    q_runs.push_back(3);
    q_final.push_back(3);
    cfg_div  = 24'd3;
    cfg_runs = 4'd3;
    press_and_launch("auto_busy");
    btn_raw  = 1'b0;
    cfg_div  = 24'd0;
    cfg_runs = 4'd1;
    tick(10);
    measure_period(per);
    check("auto_period_latched", per, 4);
    wait_done(base_done + 1, 2000, "auto_done");
    tick(20);
    check("auto_single_done", done_cnt, base_done + 1);
    check("auto_launches", launch_cnt - base_launch, 3);
    check("auto_runs_done", runs_done, 3);

    // cfg_runs = 0 behaves as one run
    base_done   = done_cnt;
    base_launch = launch_cnt;
    q_runs.push_back(1);
    q_final.push_back(1);
    cfg_div  = 24'd3;
    cfg_runs = 4'd0;
    press_and_launch("runs0_busy");
    btn_raw = 1'b0;
    wait_done(base_done + 1, 800, "runs0_done");
    tick(20);
    check("runs0_single_done", done_cnt, base_done + 1);
    check("runs0_launches", launch_cnt - base_launch, 1);
    check("runs0_runs_done", runs_done, 1);

    // Kick-back: button held into RUN is forwarded at the 003F bound
    base_done = done_cnt;
    base_kick = kick_cnt;
    q_runs.push_back(1);
    q_final.push_back(1);
    cfg_runs = 4'd1;
    press_and_launch("kick_busy");
    wait_leds(16'h003F, 200, "kick_reach_3f");
    check("kick_flick_forwarded", flick_out, 1);
    c = 0;
    while (kick_cnt == base_kick && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("kick_happened", kick_cnt - base_kick, 1);
    btn_raw = 1'b0;
    wait_done(base_done + 1, 1500, "kick_done");
    check("kick_runs_done", runs_done, 1);

    // Reset mid-run
    press_and_launch("rstmid_busy");
    btn_raw = 1'b0;
    wait_leds(16'h00FF, 200, "rstmid_reach_ff");
    check("rstmid_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_step_en", step_en, 0);
    check("rstmid_flick", flick_out, 0);
    check("rstmid_runs_done", runs_done, 0);
    tick(2);
    rst = 1'b1;
    tick(3);

    // Stalled flasher (LEDs frozen at 0001)
    base_done = done_cnt;
    base_err  = err_cnt;
    freeze    = 1'b1;
    cfg_div   = 24'd0;
    cfg_runs  = 4'd1;
    press_and_launch("wdog_busy");
    btn_raw = 1'b0;
`ifdef FLASHER_WDOG_EN
    c = 0;
    while (err_cnt == base_err && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("wdog_err_pulse", err_cnt - base_err, 1);
    tick(3);
    check("wdog_idle", busy, 0);
    check("wdog_no_done", done_cnt, base_done);
    check("wdog_runs_done_held", runs_done, 0);
    check("wdog_err_single", err_cnt - base_err, 1);
`else
    tick(300);
    check("nowdog_err_zero", err_cnt, base_err);
    check("nowdog_still_busy", busy, 1);
    check("nowdog_no_done", done_cnt, base_done);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
`endif
    freeze = 1'b0;
    tick(5);
    check("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bound_flasher_ctrl.md
Name: bound_flasher_ctrl

Overview:
- Sequencer that drives the 16-LED bound flasher from a raw push-button.
- Synchronises and debounces the button, generates the flasher's step-rate enable, and launches each run by holding flick until the flasher leaves INIT.
- Forwards the user's button level as the flasher's flick input while a run is in progress, so the mid-sweep kick-back still works.
- Counts completed runs, with optional auto-repeat. Sits between board I/O and the flasher instance; the flasher advances only on cycles where step_en=1.

Parameters:
- DIV_W, 24, width of step-period divider.
- DEBOUNCE_CYC, 16, cycles the synchronised button must be stable before its debounced level changes.
- RUN_W, 4, width of run-count request/counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- btn_raw  in  1  raw flick push-button, asynchronous
- cfg_div  in  DIV_W  step period minus 1, in clk cycles
- cfg_runs  in  RUN_W  runs per launch; 0 treated as 1
- leds_in  in  16  flasher LED output, fed back
- step_en  out  1  one-cycle clock-enable pulse to the flasher
- flick_out  out  1  flick level to the flasher
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the final requested run completes
- err  out  1  one-cycle pulse on watchdog abort
- runs_done  out  RUN_W  runs completed since the last launch

Behaviour:
- Reset (rst=0, async): FSM=IDLE; all outputs 0; sync, debounce, divider and counters cleared; debounced level=0. Reset mid-run takes effect immediately.
- Input conditioning:
  - btn_raw passes through a 2-FF synchroniser.
  - The debounced level btn_db updates only after the synchronised value differs from btn_db for DEBOUNCE_CYC consecutive cycles.
  - start = rising edge of btn_db (one cycle).
- Divider:
  - Runs only when busy=1; counts 0..div_q, with step_en=1 on the cycle the count equals div_q, then wraps to 0.
  - div_q = cfg_div latched on the IDLE->LAUNCH transition; div_q=0 gives step_en every cycle.
  - The counter is cleared on entry to LAUNCH, so the first step_en comes div_q+1 cycles after entry.
- FSM:
  - IDLE: flick_out=0, step_en=0. On start: latch cfg_div, latch runs_q=max(cfg_runs,1), clear runs_done, go to LAUNCH. start is ignored in every other state.
  - LAUNCH: flick_out=1. When leds_in!=0 is sampled, go to RUN.
  - RUN: flick_out=btn_db. On leds_in==16'hFFFF (BLINK), go to TAIL.
  - TAIL: flick_out=0. On leds_in==0, runs_done increments (saturating). If the new runs_done < runs_q, go to LAUNCH; else pulse done for one cycle and go to IDLE.
- cfg_div and cfg_runs changes while busy have no effect until the next launch.
- Simultaneous start and reset: reset wins.
- With cfg_runs=N, done fires exactly once, after the Nth completed run.

Optional Feature:
- Macro FLASHER_WDOG_EN.
- Defined: in LAUNCH and RUN, a 6-bit counter counts step_en pulses on which leds_in is unchanged from the previous step. It clears on any leds_in change or on state entry. When it reaches 63 with a further unchanged step, the block pulses err for one cycle and returns to IDLE without asserting done; runs_done holds its value.
- Not defined: no watchdog logic; err is tied to 0.

Test Plan:
- Bounce: btn_raw toggles every 3 cycles for 40 cycles, then holds 1 (DEBOUNCE_CYC=16) -> exactly one start; busy rises 2+16+1 cycles after the final rising edge (±1).
- Basic run: cfg_div=3, cfg_runs=1, model flasher driven by step_en -> step_en period 4 cycles; flick_out=1 until leds_in!=0; done pulses once on leds_in returning to 0 after 16'hFFFF; runs_done=1.
- Auto-repeat: cfg_runs=3 -> three LAUNCH entries, runs_done steps 1,2,3, a single done; cfg_runs=0 behaves as 1.
- Kick-back: hold btn high in RUN while leds_in=16'h003F -> flick_out=1 forwarded; flasher returns to OFF_5_TO_0 and the run still completes with done.
- Reset mid-run: rst=0 while leds_in=16'h00FF in RUN -> busy, step_en and flick_out are 0 in the same cycle; runs_done=0.
- Watchdog (FLASHER_WDOG_EN): leds_in frozen at 16'h0001 in RUN, cfg_div=0 -> err pulses after 64 unchanged steps, then IDLE with no done; without the macro, err stays 0.
